// File: rtl/mlimb_add_stream.sv
// Streaming multi-limb adder: one LIMB_W-bit limb pair per beat, with the carry
// chained across the limbs of an operand and one output register stage.
module mlimb_add_stream #(
    parameter  int LIMB_W    = 14,
    parameter  int MAX_LIMBS = 8,
    localparam int IDX_W     = $clog2(MAX_LIMBS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IV,
    output logic              IR,
    input  logic [LIMB_W-1:0] X,
    input  logic [LIMB_W-1:0] Y,
    input  logic              CIN,
    input  logic              IFIRST,
    input  logic              ILAST,
    output logic              OV,
    input  logic              OR,
    output logic [LIMB_W-1:0] S,
    output logic              OLAST,
    output logic              COUT,
    output logic [IDX_W-1:0]  IDX,
    output logic              ERR
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              r_state;
    logic                r_ov;
    logic [LIMB_W-1:0]   r_s;
    logic                r_cout;
    logic                r_creg;
    logic                r_olast;
    logic [IDX_W-1:0]    r_idx;
    logic                r_err;

    logic                w_acc;
    logic                w_run;
    logic                w_new;
    logic                w_cin;
    logic [LIMB_W:0]     w_sum;
    logic [IDX_W-1:0]    w_idx;
    logic                w_force;
    logic                w_last;
    logic                w_err;

    assign IR    = RST || !r_ov || OR;
    assign w_acc = IV && IR;
    assign w_run = (r_state == RUN);

    // A beat starts a new operand in IDLE, or when IFIRST interrupts a running one.
    // A stray non-first beat in IDLE never inherits CIN.
    assign w_new   = !w_run || IFIRST;
    assign w_cin   = w_new ? (IFIRST & CIN) : r_creg;
    assign w_sum   = {1'b0, X} + {1'b0, Y} + (LIMB_W+1)'(w_cin);
    assign w_idx   = w_new ? '0 : r_idx + IDX_W'(1);
    assign w_force = (w_idx == IDX_W'(MAX_LIMBS-1)) && !ILAST;
    assign w_last  = ILAST || w_force;
    assign w_err   = (w_run == IFIRST) || w_force;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_ov    <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_creg  <= 1'b0;
            r_olast <= 1'b0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else if (w_acc) begin
            r_ov    <= 1'b1;
            r_s     <= w_sum[LIMB_W-1:0];
            r_cout  <= w_sum[LIMB_W];
            r_creg  <= w_sum[LIMB_W];
            r_olast <= w_last;
            r_idx   <= w_idx;
            r_state <= w_last ? IDLE : RUN;
            if (w_err) r_err <= 1'b1;
        end else if (OR) begin
            r_ov    <= 1'b0;
        end
    end

    assign OV    = r_ov;
    assign S     = r_s;
    assign COUT  = r_cout;
    assign OLAST = r_olast;
    assign IDX   = r_idx;
    assign ERR   = r_err;

endmodule
